// File: rtl/mux_2x1_arbiter_if.sv
// Bus between the two requesters, the shared 2:1 mux and its consumer.
//   req0/req1 : level requests from requester 0 / 1
//   i0/i1     : requester data (WIDTH bits each)
//   gnt0/gnt1 : registered one-hot grants
//   s         : registered mux select (0 -> i0, 1 -> i1)
//   op        : muxed data, valid while op_valid is high
//   op_valid  : gnt0 | gnt1
// master : requester/consumer side; slave : arbiter side.
interface mux_2x1_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             gnt0;
    logic             gnt1;
    logic             s;
    logic [WIDTH-1:0] op;
    logic             op_valid;

    modport master (
        output req0, req1, i0, i1,
        input  gnt0, gnt1, s, op, op_valid
    );

    modport slave (
        input  req0, req1, i0, i1,
        output gnt0, gnt1, s, op, op_valid
    );
endinterface

// File: rtl/mux_2x1_arbiter.sv
// Round-robin arbiter in front of a 2:1 data mux. Grants one requester at a
// time; an owner is forced to hand over after MAX_HOLD cycles only when the
// other side is waiting, otherwise it keeps the grant indefinitely.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : mux_2x1_arbiter_if slave modport (requests, data, grants, mux out)
//
// state  | meaning
// IDLE   | no owner; s holds the last select
// GRANT0 | requester 0 owns the mux, s=0
// GRANT1 | requester 1 owns the mux, s=1
module mux_2x1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_2x1_arbiter_if.slave      bus
);
    localparam int CNT_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] op_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            s_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                // On a tie, last_q=1 means requester 1 was served last, so 0 wins.
                if (bus.req0 && (!bus.req1 || last_q)) begin
                    state_d = GRANT0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    s_d     = 1'b0;
                end else if (bus.req1) begin
                    state_d = GRANT1;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                    s_d     = 1'b1;
                end
            end
            GRANT0: begin
                if (!bus.req0 || (bus.req1 && cnt_q == HOLD_LAST)) begin
                    if (bus.req1) begin
                        state_d = GRANT1;
                        cnt_d   = '0;
                        last_d  = 1'b1;
                        s_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GRANT1: begin
                if (!bus.req1 || (bus.req0 && cnt_q == HOLD_LAST)) begin
                    if (bus.req0) begin
                        state_d = GRANT0;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        s_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // op is deliberately ungated; the consumer qualifies it with op_valid.
    assign op_mux       = s_q ? bus.i1 : bus.i0;
    assign bus.op       = op_mux;
    assign bus.s        = s_q;
    assign bus.gnt0     = (state_q == GRANT0);
    assign bus.gnt1     = (state_q == GRANT1);
    assign bus.op_valid = (state_q == GRANT0) || (state_q == GRANT1);
endmodule

// File: tb/tb_mux_2x1_arbiter.sv
module tb_mux_2x1_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;

    mux_2x1_arbiter_if #(.WIDTH(8)) bus4 ();
    mux_2x1_arbiter_if #(.WIDTH(8)) bus1 ();

    mux_2x1_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    mux_2x1_arbiter #(.WIDTH(8), .MAX_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Reference model: who owns the mux, for how many cycles so far, who was
    // served last, and the current select. Index 0 -> MAX_HOLD=4, 1 -> MAX_HOLD=1.
    int owner [2];
    int held  [2];
    int lastsv[2];
    int sel   [2];
    int mh    [2] = '{4, 1};

    task automatic give(input int k, input int who);
        owner[k]  = who;
        held[k]   = 1;
        lastsv[k] = who;
        sel[k]    = who;
    endtask

    task automatic model_step(input int k, input logic r0, input logic r1, input logic rr);
        int want [2];
        want[0] = int'(r0);
        want[1] = int'(r1);
        if (rr) begin
            owner[k] = -1; held[k] = 0; lastsv[k] = 1; sel[k] = 0;
        end else if (owner[k] < 0) begin
            if (want[0] == 1 && want[1] == 1) give(k, 1 - lastsv[k]);
            else if (want[0] == 1)            give(k, 0);
            else if (want[1] == 1)            give(k, 1);
        end else begin
            int x = owner[k];
            int y = 1 - x;
            if (want[x] == 0) begin
                if (want[y] == 1) give(k, y);
                else owner[k] = -1;
            end else if (want[y] == 1 && held[k] >= mh[k]) begin
                give(k, y);
            end else begin
                held[k] = held[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic g0, input logic g1, input logic s,
                             input logic v, input logic [7:0] op);
        logic [7:0] eop;
        eop = (sel[k] == 1) ? d1 : d0;
        chk("gnt0",     k, {7'd0, g0}, {7'd0, owner[k] == 0});
        chk("gnt1",     k, {7'd0, g1}, {7'd0, owner[k] == 1});
        chk("s",        k, {7'd0, s},  {7'd0, sel[k] == 1});
        chk("op_valid", k, {7'd0, v},  {7'd0, owner[k] >= 0});
        chk("op",       k, op, eop);
    endtask

    task automatic step(input logic r0, input logic r1, input logic rr);
        bus4.req0 = r0; bus4.req1 = r1; bus4.i0 = d0; bus4.i1 = d1;
        bus1.req0 = r0; bus1.req1 = r1; bus1.i0 = d0; bus1.i1 = d1;
        rst = rr;
        @(posedge clk);
        model_step(0, r0, r1, rr);
        model_step(1, r0, r1, rr);
        #1;
        check_dut(0, bus4.gnt0, bus4.gnt1, bus4.s, bus4.op_valid, bus4.op);
        check_dut(1, bus1.gnt0, bus1.gnt1, bus1.s, bus1.op_valid, bus1.op);
    endtask

    initial begin
        logic r0, r1, rr;
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; held[k] = 0; lastsv[k] = 1; sel[k] = 0;
        end

        // Reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("reset_valid", 0, {7'd0, bus4.op_valid}, 8'h00);

        // Single uncontended requester keeps the grant
        d0 = 8'hA5; d1 = 8'h3C;
        step(1'b1, 1'b0, 1'b0);
        chk("first_gnt0", 0, {7'd0, bus4.gnt0}, 8'h01);
        chk("first_op",   0, bus4.op, 8'hA5);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);
        chk("held_gnt0", 0, {7'd0, bus4.gnt0}, 8'h01);

        // Tie from IDLE after reset: 0 first, then 4/4 alternation
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0);

        // Handover: gnt1 owner drops at its 2nd cycle while req0 waits
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("ho_gnt1", 0, {7'd0, bus4.gnt1}, 8'h01);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("ho_gnt0", 0, {7'd0, bus4.gnt0}, 8'h01);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);

        // Release to IDLE keeps s; later tie goes to the one not served last
        d0 = 8'h11; d1 = 8'hEE;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Reset mid-grant with both requests held
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("rst_mid_s", 0, {7'd0, bus4.s}, 8'h00);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_gnt0", 0, {7'd0, bus4.gnt0}, 8'h01);
        step(1'b1, 1'b1, 1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            r0 = ($urandom_range(0, 9) < 7);
            r1 = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 59) == 0);
            step(r0, r1, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux_2x1_arbiter.md
# mux_2x1_arbiter

Round-robin arbiter that shares one 2:1 multiplexer datapath between two requesters. Each requester raises a request; the block grants exactly one owner at a time, drives the mux select accordingly, and bounds each ownership to MAX_HOLD cycles whenever the other side is waiting. It sits directly in front of the 2:1 mux datapath and produces the muxed output plus a valid flag for the downstream consumer.

## Interface
- WIDTH, 8: data width of each requester's input and of the muxed output.
- MAX_HOLD, 4: maximum consecutive grant cycles for one owner while the other requester is pending; legal range 1..255.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- req0  input  1  requester 0 request; level, held high while it wants the datapath.
- req1  input  1  requester 1 request.
- i0  input  WIDTH  requester 0 data.
- i1  input  WIDTH  requester 1 data.
- gnt0  output  1  registered grant to requester 0.
- gnt1  output  1  registered grant to requester 1.
- s  output  1  registered mux select; 0 selects i0, 1 selects i1.
- op  output  WIDTH  muxed data, s ? i1 : i0; combinational from the registered s.
- op_valid  output  1  high exactly when gnt0 | gnt1.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. gnt0 = (state==GRANT0), gnt1 = (state==GRANT1); never both high.
- Internal: last (1 bit, last granted requester), cnt (hold counter, width ceil(log2(MAX_HOLD)) and at least 1).
- Reset: state=IDLE, gnt0=gnt1=0, op_valid=0, s=0, cnt=0, last=1. With last=1, requester 0 wins the first tie.
- IDLE:
  - Only req0 -> GRANT0.
  - Only req1 -> GRANT1.
  - Both -> grant the requester != last.
  - Neither -> stay in IDLE; s holds its previous value.
- GRANTx (owner x, other y):
  - If !reqx: go to GRANTy when reqy is high, else IDLE.
  - Else if reqy and cnt==MAX_HOLD-1: go to GRANTy.
  - Else stay, with cnt = min(cnt+1, MAX_HOLD-1).
- Entering any GRANTx: cnt=0, last=x, s=x.
- Switching between grants is direct; no idle bubble is inserted.
- Uncontended owner keeps the grant indefinitely (cnt saturates).
- MAX_HOLD=1: under continuous contention, grants alternate every cycle.
- op is not gated. When op_valid=0, op still shows the input selected by s, and the consumer ignores it.

## Timing
- Request-to-grant latency is 1 cycle: req sampled high at edge N -> gnt/s/op_valid high after edge N.
- Release latency is 1 cycle: owner drops req before edge N -> its gnt falls after edge N; the other's gnt rises at the same edge if it is requesting.
- Under continuous contention each owner holds for exactly MAX_HOLD cycles.
- op follows i0/i1 combinationally within the cycle, with no data register.
- rst high at an edge overrides everything: next cycle is IDLE, grants 0, s=0, last=1, regardless of the requests. Requests held through reset are granted 1 cycle after rst falls.
- Simultaneous owner release and other request at the same edge -> direct handover, with no cycle where op_valid=0.

## Test plan
- Reset, then req0=1 only, i0=8'hA5, i1=8'h3C -> 1 cycle later gnt0=1, s=0, op=8'hA5, op_valid=1; gnt0 remains high for 10+ cycles with no forced release.
- From IDLE after reset, req0=req1=1 simultaneously -> gnt0 first (last reset to 1). With MAX_HOLD=4: gnt0 for 4 cycles, gnt1 for 4 cycles, then alternating; op toggles between i0 and i1 with no op_valid gap.
- Owner handover: gnt1 active with req0=1, req1 dropped at cycle 2 of the grant -> gnt0 next cycle, s=0, cnt restarts so gnt0 is held for 4 cycles.
- Release to IDLE: single owner drops req with the other idle -> both grants 0 next cycle, op_valid=0, s keeps its last value. A later tie grants the requester not served last.
- MAX_HOLD=1, both requesting continuously -> gnt0/gnt1 alternate every cycle and s toggles each cycle.
- Reset mid-grant: rst=1 for one cycle while gnt1 is active and both requests are held -> grants 0, s=0 during the next cycle, then gnt0 one cycle after rst deasserts.
